debug_reporter: RTL and testbench

//  Run-control and result-reporting stage downstream of the accumulator CPU top.
//  - Holds the CPU disabled until a start request.
//  - Counts execution cycles and detects the halt instruction.
//  - Snapshots PC and accumulator on halt.
//  - Streams an 8-byte report frame over a byte valid/ready interface to the UART transmitter.

---
 rtl/debug_reporter.sv | 119 +++++++++++
 tb/tb_debug_reporter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_reporter.sv
// debug_reporter: holds the CPU until a start request, counts execution cycles
// up to the halt instruction, snapshots PC/accumulator, then streams an 8-byte
// report frame (header, PC, ACC, cycle count, XOR checksum) over a byte
// valid/ready link to the UART transmitter.
module debug_reporter #(
  parameter int          PC_BITS  = 11,
  parameter int          ACC_BITS = 16,
  parameter int          CNT_BITS = 16,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_halt,
  input  logic [PC_BITS-1:0]  i_pc,
  input  logic [ACC_BITS-1:0] i_acc,
  output logic                o_cpu_en,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [1:0] {IDLE, RUN, SEND, DONE} state_t;

  state_t              state;
  state_t              state_nx;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_inc;
  logic [15:0]         pc_snap;
  logic [15:0]         acc_snap;
  logic [15:0]         cyc_snap;
  logic [2:0]          idx;
  logic                accept;
  logic [7:0]          frame_byte;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + {{(CNT_BITS-1){1'b0}}, 1'b1};
  endfunction

  // Checksum byte: XOR of the seven payload bytes (header included).
  function automatic logic [7:0] frame_xor(input logic [15:0] p, input logic [15:0] a,
                                           input logic [15:0] c);
    return HEADER ^ p[15:8] ^ p[7:0] ^ a[15:8] ^ a[7:0] ^ c[15:8] ^ c[7:0];
  endfunction

  assign cnt_inc = sat_inc(cnt);
  assign accept  = (state == SEND) && i_tx_ready;

  // State register; reset wins over any transition, abandoning a partial frame.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state decode; i_start only matters in IDLE/DONE, i_halt only in RUN.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = RUN;
      RUN:     if (i_halt) state_nx = SEND;
      SEND:    if (accept && (idx == 3'd7)) state_nx = DONE;
      DONE:    if (i_start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Cycle counter, halt snapshot and frame byte index.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt      <= '0;
      pc_snap  <= '0;
      acc_snap <= '0;
      cyc_snap <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (i_start) cnt <= '0;
        RUN: begin
          cnt <= cnt_inc;
          if (i_halt) begin
            // The halt cycle itself is counted, hence cnt_inc rather than cnt.
            pc_snap  <= 16'(i_pc);
            acc_snap <= 16'(i_acc);
            cyc_snap <= 16'(cnt_inc);
            idx      <= '0;
          end
        end
        SEND: if (accept) idx <= idx + 3'd1;
        default: ;
      endcase
    end
  end

  // Frame byte selected by the index; held stable until the transmitter accepts it.
  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      3'd0: frame_byte = HEADER;
      3'd1: frame_byte = pc_snap[15:8];
      3'd2: frame_byte = pc_snap[7:0];
      3'd3: frame_byte = acc_snap[15:8];
      3'd4: frame_byte = acc_snap[7:0];
      3'd5: frame_byte = cyc_snap[15:8];
      3'd6: frame_byte = cyc_snap[7:0];
      3'd7: frame_byte = frame_xor(pc_snap, acc_snap, cyc_snap);
      default: frame_byte = 8'h00;
    endcase
  end

  assign o_cpu_en   = (state == RUN);
  assign o_tx_valid = (state == SEND);
  assign o_tx_data  = (state == SEND) ? frame_byte : 8'h00;
  assign o_busy     = (state == RUN) || (state == SEND);
  assign o_done     = (state == DONE);

endmodule

// File: tb/tb_debug_reporter.sv
// Testbench for debug_reporter: table-driven frames, multi-cycle corner
// sequences and randomized runs against a frame model built from the rules.
module tb_debug_reporter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic [10:0] pc;
  logic [15:0] acc;
  logic        cpu_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        ready;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  typedef logic [0:7][7:0] frame_t;

  typedef struct {
    logic [10:0] pc;
    logic [15:0] acc;
    int          len;
    int          rmode;
    frame_t      exp;
  } vec_t;

  vec_t vecs[4];

  debug_reporter dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_halt     (halt),
    .i_pc       (pc),
    .i_acc      (acc),
    .o_cpu_en   (cpu_en),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (ready),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference frame: header, zero-extended PC and ACC, cycle count clamped
  // to 65535, then the XOR of the first seven bytes.
  function automatic frame_t model(input logic [10:0] p, input logic [15:0] a, input int len);
    frame_t      f;
    logic [15:0] p16;
    logic [15:0] c16;
    int          cyc;
    cyc  = (len > 65535) ? 65535 : len;
    c16  = cyc[15:0];
    p16  = {5'b0, p};
    f[0] = 8'hA5;
    f[1] = p16[15:8];
    f[2] = p16[7:0];
    f[3] = a[15:8];
    f[4] = a[7:0];
    f[5] = c16[15:8];
    f[6] = c16[7:0];
    f[7] = 8'h00;
    for (int i = 0; i < 7; i++) f[7] = f[7] ^ f[i];
    return f;
  endfunction

  // Start a run, halt after len RUN cycles, then collect bytes with the chosen
  // ready pattern (0: always, 1: one cycle in three, 2: random). Stops after
  // abort_at accepted bytes when abort_at < 8.
  task automatic run_frame(input logic [10:0] p, input logic [15:0] a, input int len,
                           input int rmode, input bit noise, input int abort_at,
                           output frame_t got, output int nbytes, output int ncyc,
                           output bit stable_ok, output bit en_ok, output bit first_valid);
    bit         pend;
    logic [7:0] pdata;
    got   = '0;
    pc    = p;
    acc   = a;
    halt  = 1'b0;
    ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    en_ok = 1'b1;
    for (int k = 1; k <= len; k++) begin
      if (cpu_en !== 1'b1 || busy !== 1'b1 || tx_valid !== 1'b0) en_ok = 1'b0;
      halt = (k == len);
      if (noise) start = 1'($urandom_range(0, 1));
      step();
    end
    halt  = 1'b0;
    start = 1'b0;
    pc    = 11'($urandom);
    acc   = 16'($urandom);
    if (cpu_en !== 1'b0) en_ok = 1'b0;
    first_valid = tx_valid;
    nbytes    = 0;
    ncyc      = 0;
    stable_ok = 1'b1;
    pend      = 1'b0;
    pdata     = 8'h00;
    while (nbytes < 8 && nbytes < abort_at && ncyc < 200) begin
      if (pend && (tx_valid !== 1'b1 || tx_data !== pdata)) stable_ok = 1'b0;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = ((ncyc % 3) == 2);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        halt  = 1'($urandom_range(0, 1));
      end
      if (tx_valid === 1'b1 && ready) begin
        got[nbytes] = tx_data;
        nbytes++;
        pend = 1'b0;
      end else begin
        pend  = (tx_valid === 1'b1);
        pdata = tx_data;
      end
      ncyc++;
      step();
    end
    ready = 1'b0;
    start = 1'b0;
    halt  = 1'b0;
  endtask

  task automatic check_frame(input string name, input frame_t got, input frame_t exp,
                             input int nbytes, input bit stable_ok, input bit en_ok,
                             input bit first_valid);
    check({name, "_bytes"}, got, exp);
    check({name, "_count"}, 64'(nbytes), 64'd8);
    check({name, "_stable"}, 64'(stable_ok), 64'd1);
    check({name, "_run_en"}, 64'(en_ok), 64'd1);
    check({name, "_latency"}, 64'(first_valid), 64'd1);
    check({name, "_done"}, {61'd0, done, tx_valid, busy}, {61'd0, 3'b100});
  endtask

  initial begin
    frame_t got;
    int     nb;
    int     nc;
    bit     st;
    bit     en;
    bit     fv;
    logic [10:0] rp;
    logic [15:0] ra;
    int          rl;

    vecs[0] = '{pc: 11'h005, acc: 16'h1234, len: 6,   rmode: 0,
                exp: {8'hA5, 8'h00, 8'h05, 8'h12, 8'h34, 8'h00, 8'h06, 8'h80}};
    vecs[1] = '{pc: 11'h005, acc: 16'h1234, len: 6,   rmode: 1,
                exp: {8'hA5, 8'h00, 8'h05, 8'h12, 8'h34, 8'h00, 8'h06, 8'h80}};
    vecs[2] = '{pc: 11'h7FF, acc: 16'hFFFF, len: 1,   rmode: 0,
                exp: {8'hA5, 8'h07, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h5C}};
    vecs[3] = '{pc: 11'h123, acc: 16'hBEEF, len: 300, rmode: 1,
                exp: {8'hA5, 8'h01, 8'h23, 8'hBE, 8'hEF, 8'h01, 8'h2C, 8'hFB}};

    rst   = 1'b1;
    start = 1'b0;
    halt  = 1'b0;
    ready = 1'b0;
    pc    = '0;
    acc   = '0;
    step();
    step();
    check("reset_outputs", {51'd0, cpu_en, tx_valid, busy, done, tx_data},
          {51'd0, 4'b0000, 8'h00});
    rst = 1'b0;

    // Idle: halt and ready asserted must not wake anything up.
    halt  = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("idle_%0d", i), {60'd0, cpu_en, tx_valid, busy, done}, 64'd0);
    end
    halt  = 1'b0;
    ready = 1'b0;
    step();

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].pc, vecs[v].acc, vecs[v].len, vecs[v].rmode, 1'b0, 8,
                got, nb, nc, st, en, fv);
      check_frame($sformatf("vec%0d", v), got, vecs[v].exp, nb, st, en, fv);
      if (vecs[v].rmode == 0) check($sformatf("vec%0d_b2b", v), 64'(nc), 64'd8);
    end

    // Long run: cycle count saturates.
    run_frame(11'h2AA, 16'h0F0F, 70000, 0, 1'b0, 8, got, nb, nc, st, en, fv);
    check_frame("sat", got, model(11'h2AA, 16'h0F0F, 70000), nb, st, en, fv);
    check("sat_cyc", {48'd0, got[5], got[6]}, 64'hFFFF);

    // Start from DONE, halt on first RUN cycle, with start/halt noise during SEND.
    run_frame(11'h0A0, 16'h5555, 1, 2, 1'b1, 8, got, nb, nc, st, en, fv);
    check_frame("restart", got, model(11'h0A0, 16'h5555, 1), nb, st, en, fv);
    check("restart_cyc", {48'd0, got[5], got[6]}, 64'h0001);

    // Reset after byte 3 accepted: frame abandoned.
    run_frame(11'h111, 16'hAAAA, 9, 0, 1'b0, 4, got, nb, nc, st, en, fv);
    check("abort_sent", 64'(nb), 64'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_idle", {51'd0, cpu_en, tx_valid, busy, done, tx_data},
          {51'd0, 4'b0000, 8'h00});
    step();
    check("abort_still_idle", {60'd0, cpu_en, tx_valid, busy, done}, 64'd0);
    run_frame(11'h3C3, 16'h8001, 12, 1, 1'b0, 8, got, nb, nc, st, en, fv);
    check_frame("fresh", got, model(11'h3C3, 16'h8001, 12), nb, st, en, fv);

    // Randomized runs against the frame model.
    for (int r = 0; r < 10; r++) begin
      rp = 11'($urandom);
      ra = 16'($urandom);
      rl = int'($urandom_range(1, 50));
      run_frame(rp, ra, rl, 2, 1'b1, 8, got, nb, nc, st, en, fv);
      check_frame($sformatf("rand%0d", r), got, model(rp, ra, rl), nb, st, en, fv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
